// File: rtl/calc_entry_if.sv
// Key-entry and display bundle of the calculator entry block.
// The master drives keys and the slave (calc_entry) drives the display and status.
interface calc_entry_if;
  logic        mode;
  logic        key_press;
  logic [4:0]  val;
  logic [15:0] display;
  logic [1:0]  state;
  logic [2:0]  op_sel;
  logic [2:0]  ndigits;
  logic        result_valid;
  logic        ovf;

  modport master (
    output mode, key_press, val,
    input  display, state, op_sel, ndigits, result_valid, ovf
  );
  modport slave (
    input  mode, key_press, val,
    output display, state, op_sel, ndigits, result_valid, ovf
  );
endinterface

// File: rtl/calc_entry.sv
// Calculator key-entry FSM: collects operand A, an operator and operand B in HEX or DEC,
// computes 16-bit unsigned results and supports chained operators.
module calc_entry (
  input  logic         clk,
  input  logic         rst,
  calc_entry_if.slave  bus
);
  typedef enum logic [1:0] {S_A = 2'd0, S_OP = 2'd1, S_B = 2'd2, S_RES = 2'd3} state_t;

  localparam logic [4:0] K_EXE = 5'h13, K_CE = 5'h16, K_CLR = 5'h17;
  localparam logic [2:0] OP_NONE = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2,
                         OP_MUL = 3'd3, OP_AND = 3'd4, OP_OR = 3'd5;

  state_t      st;
  logic [15:0] a_q, b_q, r_q;
  logic [2:0]  op_q, nd_q;
  logic        rv_q, ovf_q;

  logic        is_dig, is_op, is_exe, is_ce, is_clr, do_clr;
  logic [2:0]  op_code;
  logic [3:0]  dig;
  logic [16:0] sum, diff;
  logic [31:0] prod;
  logic [15:0] r_calc;
  logic        ovf_calc;

  function automatic logic [15:0] append(input logic [15:0] acc, input logic [3:0] d,
                                         input logic dec);
    return dec ? (acc * 16'd10 + {12'd0, d}) : {acc[11:0], d};
  endfunction

  // Key decode; DEC digits above 9 are treated as invalid codes
  always_comb begin
    dig     = bus.val[3:0];
    is_dig  = bus.key_press && !bus.val[4] && (!bus.mode || bus.val[3:0] <= 4'd9);
    case (bus.val)
      5'h10:   op_code = OP_ADD;
      5'h11:   op_code = OP_MUL;
      5'h12:   op_code = OP_AND;
      5'h14:   op_code = OP_SUB;
      5'h15:   op_code = OP_OR;
      default: op_code = OP_NONE;
    endcase
    is_op   = bus.key_press && (op_code != OP_NONE);
    is_exe  = bus.key_press && (bus.val == K_EXE);
    is_ce   = bus.key_press && (bus.val == K_CE);
    is_clr  = bus.key_press && (bus.val == K_CLR);
    // CE on a shown result clears everything, exactly like CLR
    do_clr  = !rst || is_clr || (is_ce && st == S_RES);
  end

  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    prod     = {16'd0, a_q} * {16'd0, b_q};
    r_calc   = 16'd0;
    ovf_calc = 1'b0;
    case (op_q)
      OP_ADD:  begin r_calc = sum[15:0];  ovf_calc = sum[16];       end
      OP_SUB:  begin r_calc = diff[15:0]; ovf_calc = diff[16];      end
      OP_MUL:  begin r_calc = prod[15:0]; ovf_calc = |prod[31:16];  end
      OP_AND:  r_calc = a_q & b_q;
      OP_OR:   r_calc = a_q | b_q;
      default: r_calc = 16'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_clr) begin
      st <= S_A; a_q <= '0; b_q <= '0; r_q <= '0;
      op_q <= OP_NONE; nd_q <= '0; rv_q <= 1'b0; ovf_q <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      case (st)
        S_A: begin
          if (is_dig) begin
            if (nd_q < 3'd4) begin a_q <= append(a_q, dig, bus.mode); nd_q <= nd_q + 3'd1; end
          end else if (is_op) begin
            op_q <= op_code; st <= S_OP; nd_q <= '0;
          end else if (is_ce) begin
            a_q <= '0; nd_q <= '0;
          end
        end
        S_OP: begin
          if (is_dig) begin
            b_q <= {12'd0, dig}; nd_q <= 3'd1; st <= S_B;
          end else if (is_op) begin
            op_q <= op_code;
          end else if (is_ce) begin
            op_q <= OP_NONE; st <= S_A; nd_q <= '0;
          end
        end
        S_B: begin
          if (is_dig) begin
            if (nd_q < 3'd4) begin b_q <= append(b_q, dig, bus.mode); nd_q <= nd_q + 3'd1; end
          end else if (is_exe || is_op) begin
            r_q <= r_calc; ovf_q <= ovf_calc; rv_q <= 1'b1; nd_q <= '0;
            if (is_op) begin
              // chaining: result becomes the new A and the new operator is latched
              a_q <= r_calc; op_q <= op_code; st <= S_OP;
            end else begin
              st <= S_RES;
            end
          end else if (is_ce) begin
            b_q <= '0; nd_q <= '0;
          end
        end
        S_RES: begin
          if (is_dig) begin
            a_q <= {12'd0, dig}; nd_q <= 3'd1; op_q <= OP_NONE; st <= S_A;
          end else if (is_op) begin
            a_q <= r_q; op_q <= op_code; st <= S_OP; nd_q <= '0;
          end
        end
        default: st <= S_A;
      endcase
    end
  end

  always_comb begin
    case (st)
      S_B:     bus.display = b_q;
      S_RES:   bus.display = r_q;
      default: bus.display = a_q;
    endcase
  end

  assign bus.state        = st;
  assign bus.op_sel       = op_q;
  assign bus.ndigits      = nd_q;
  assign bus.result_valid = rv_q;
  assign bus.ovf          = ovf_q;
endmodule

// File: tb/tb_calc_entry.sv
// Directed table-driven bench for calc_entry: each row is one key press and the
// complete expected output set one clock later.
module tb_calc_entry;
  logic clk = 1'b0;
  logic rst = 1'b0;
  calc_entry_if bus ();

  calc_entry dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam logic H = 1'b0, D = 1'b1;
  localparam logic [4:0] ADD = 5'h10, MUL = 5'h11, AND = 5'h12, EXE = 5'h13,
                         SUB = 5'h14, OR = 5'h15, CE = 5'h16, CLR = 5'h17;

  typedef struct {
    logic        m;
    logic [4:0]  v;
    logic [25:0] exp;
  } vec_t;

  vec_t tv[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [25:0] e(input logic [15:0] d, input logic [1:0] s,
                                    input logic [2:0] op, input logic [2:0] nd,
                                    input logic rv, input logic ovf);
    return {d, s, op, nd, rv, ovf};
  endfunction

  function automatic logic [25:0] obs();
    return {bus.display, bus.state, bus.op_sel, bus.ndigits, bus.result_valid, bus.ovf};
  endfunction

  task automatic add(input logic m, input logic [4:0] v, input logic [25:0] x);
    vec_t r;
    r.m = m; r.v = v; r.exp = x;
    tv.push_back(r);
  endtask

  task automatic check(input string nm, input logic [25:0] x);
    logic [25:0] g;
    g = obs();
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s: got disp=%h st=%0d op=%0d nd=%0d rv=%0d ovf=%0d, want disp=%h st=%0d op=%0d nd=%0d rv=%0d ovf=%0d",
               nm, g[25:10], g[9:8], g[7:5], g[4:2], g[1], g[0],
               x[25:10], x[9:8], x[7:5], x[4:2], x[1], x[0]);
    end
  endtask

  task automatic press(input logic m, input logic [4:0] v);
    @(negedge clk);
    bus.mode = m; bus.val = v; bus.key_press = 1'b1;
    @(posedge clk);
    #1 bus.key_press = 1'b0;
  endtask

  localparam logic [25:0] Z = 26'd0;

  initial begin
    bus.mode = 1'b0; bus.val = 5'd0; bus.key_press = 1'b0;

    // HEX 1,2,ADD,3,EXE
    add(H, 5'h1, e(16'h0001, 0, 0, 1, 0, 0));
    add(H, 5'h2, e(16'h0012, 0, 0, 2, 0, 0));
    add(H, ADD,  e(16'h0012, 1, 1, 0, 0, 0));
    add(H, 5'h3, e(16'h0003, 2, 1, 1, 0, 0));
    add(H, EXE,  e(16'h0015, 3, 1, 0, 1, 0));
    add(H, CLR,  Z);
    // EXE in S_A is ignored
    add(H, EXE,  Z);
    // DEC 1,2,(A ignored),ADD,3,EXE
    add(D, 5'h1, e(16'h0001, 0, 0, 1, 0, 0));
    add(D, 5'h2, e(16'h000C, 0, 0, 2, 0, 0));
    add(D, 5'hA, e(16'h000C, 0, 0, 2, 0, 0));
    add(D, ADD,  e(16'h000C, 1, 1, 0, 0, 0));
    add(D, 5'h3, e(16'h0003, 2, 1, 1, 0, 0));
    add(D, EXE,  e(16'h000F, 3, 1, 0, 1, 0));
    add(H, CLR,  Z);
    // HEX chaining 5,MUL,3,ADD,2,EXE then a fresh digit
    add(H, 5'h5, e(16'h0005, 0, 0, 1, 0, 0));
    add(H, MUL,  e(16'h0005, 1, 3, 0, 0, 0));
    add(H, 5'h3, e(16'h0003, 2, 3, 1, 0, 0));
    add(H, ADD,  e(16'h000F, 1, 1, 0, 1, 0));
    add(H, 5'h2, e(16'h0002, 2, 1, 1, 0, 0));
    add(H, EXE,  e(16'h0011, 3, 1, 0, 1, 0));
    add(H, 5'h7, e(16'h0007, 0, 0, 1, 0, 0));
    add(H, CLR,  Z);
    // entry limit then CE
    add(H, 5'h1, e(16'h0001, 0, 0, 1, 0, 0));
    add(H, 5'h2, e(16'h0012, 0, 0, 2, 0, 0));
    add(H, 5'h3, e(16'h0123, 0, 0, 3, 0, 0));
    add(H, 5'h4, e(16'h1234, 0, 0, 4, 0, 0));
    add(H, 5'h5, e(16'h1234, 0, 0, 4, 0, 0));
    add(H, CE,   Z);
    // SUB borrow, MUL from result with overflow, CE in S_RES acts as CLR
    add(H, 5'h2, e(16'h0002, 0, 0, 1, 0, 0));
    add(H, SUB,  e(16'h0002, 1, 2, 0, 0, 0));
    add(H, 5'h3, e(16'h0003, 2, 2, 1, 0, 0));
    add(H, EXE,  e(16'hFFFF, 3, 2, 0, 1, 1));
    add(H, MUL,  e(16'hFFFF, 1, 3, 0, 0, 1));
    add(H, 5'h2, e(16'h0002, 2, 3, 1, 0, 1));
    add(H, EXE,  e(16'hFFFE, 3, 3, 0, 1, 1));
    add(H, CE,   Z);
    // mode change mid-entry, CE in S_OP and S_B, AND, repeated EXE, invalid code
    add(H, 5'hA, e(16'h000A, 0, 0, 1, 0, 0));
    add(D, 5'h5, e(16'h0069, 0, 0, 2, 0, 0));
    add(D, OR,   e(16'h0069, 1, 5, 0, 0, 0));
    add(D, CE,   e(16'h0069, 0, 0, 0, 0, 0));
    add(D, AND,  e(16'h0069, 1, 4, 0, 0, 0));
    add(D, 5'hF, e(16'h0069, 1, 4, 0, 0, 0));
    add(H, 5'hF, e(16'h000F, 2, 4, 1, 0, 0));
    add(H, CE,   e(16'h0000, 2, 4, 0, 0, 0));
    add(H, 5'hE, e(16'h000E, 2, 4, 1, 0, 0));
    add(H, EXE,  e(16'h0008, 3, 4, 0, 1, 0));
    add(H, EXE,  e(16'h0008, 3, 4, 0, 0, 0));
    add(H, 5'h1F,e(16'h0008, 3, 4, 0, 0, 0));
    add(H, CLR,  Z);
    // ADD carry out, then operator from result keeps ovf
    add(H, 5'hF, e(16'h000F, 0, 0, 1, 0, 0));
    add(H, 5'hF, e(16'h00FF, 0, 0, 2, 0, 0));
    add(H, 5'hF, e(16'h0FFF, 0, 0, 3, 0, 0));
    add(H, 5'hF, e(16'hFFFF, 0, 0, 4, 0, 0));
    add(H, ADD,  e(16'hFFFF, 1, 1, 0, 0, 0));
    add(H, 5'h1, e(16'h0001, 2, 1, 1, 0, 0));
    add(H, EXE,  e(16'h0000, 3, 1, 0, 1, 1));
    add(H, OR,   e(16'h0000, 1, 5, 0, 0, 1));
    add(H, CLR,  Z);

    // reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset", Z);
    @(negedge clk) rst = 1'b1;

    foreach (tv[i]) begin
      press(tv[i].m, tv[i].v);
      check($sformatf("vec%0d", i), tv[i].exp);
    end

    // no key_press: valid digit on val must be ignored
    press(H, 5'h3);
    check("idle_pre", e(16'h0003, 0, 0, 1, 0, 0));
    @(negedge clk) bus.val = 5'h4;
    @(posedge clk); #1;
    check("idle_nokey", e(16'h0003, 0, 0, 1, 0, 0));

    // reset in S_B with a simultaneous key press
    press(H, ADD);
    press(H, 5'h2);
    check("pre_rst_sb", e(16'h0002, 2, 1, 1, 0, 0));
    @(negedge clk);
    rst = 1'b0; bus.val = 5'h5; bus.key_press = 1'b1;
    @(posedge clk); #1;
    bus.key_press = 1'b0;
    check("rst_in_sb", Z);
    @(negedge clk) rst = 1'b1;

    // reset during the result_valid cycle
    press(H, 5'hF);
    press(H, MUL);
    press(H, 5'h2);
    press(H, EXE);
    check("pre_rst_rv", e(16'h001E, 3, 3, 0, 1, 0));
    @(negedge clk);
    rst = 1'b0; bus.val = EXE; bus.key_press = 1'b1;
    @(posedge clk); #1;
    bus.key_press = 1'b0;
    check("rst_in_rv", Z);
    @(negedge clk) rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
